// File: rtl/pipe_slice_if.sv
// Valid/ready stream bundle for pipe_slice: upstream side, downstream side, flush and debug occupancy.
// The slice takes the slave view; whatever drives and consumes the stream takes the master view.
interface pipe_slice_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [1:0]            occupancy;

  modport master (
    output flush, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );

  modport slave (
    input  flush, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );
endinterface

// File: rtl/pipe_slice.sv
// Valid/ready pipeline slice: MODE 0 bypass, MODE 1 forward register, MODE 2 two-entry skid buffer.
// Used to cut timing paths on streaming interfaces; flush drains held entries, occupancy is for debug.
module pipe_slice #(
  parameter int DATA_WIDTH = 32,
  parameter int MODE       = 2
) (
  input logic         clk,
  input logic         rst,
  pipe_slice_if.slave bus
);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("pipe_slice: MODE must be 0, 1 or 2");
  end

  if (MODE == 0) begin : g_bypass
    logic w_unused;
    assign w_unused      = &{1'b0, clk, rst, bus.flush};
    assign bus.out_data  = bus.in_data;
    assign bus.out_valid = bus.in_valid;
    assign bus.in_ready  = bus.out_ready;
    assign bus.occupancy = 2'd0;
  end

  if (MODE == 1) begin : g_fwd
    logic                  r_main_valid;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic                  w_in_ready;
    logic                  w_in_xfer;
    logic                  w_out_xfer;

    assign w_in_ready = !r_main_valid || bus.out_ready;
    assign w_in_xfer  = bus.in_valid && w_in_ready;
    assign w_out_xfer = r_main_valid && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_valid <= 1'b0;
      end else if (bus.flush) begin
        r_main_valid <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
      end else if (w_out_xfer) begin
        r_main_valid <= 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_data <= '0;
      end else if (w_in_xfer && !bus.flush) begin
        r_main_data <= bus.in_data;
      end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.occupancy = {1'b0, r_main_valid};
  end

  if (MODE == 2) begin : g_skid
    typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_in_ready;
    logic [DATA_WIDTH-1:0] r_main_data;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic                  w_main_valid;
    logic [1:0]            w_occ;
    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_load_main_in;
    logic                  w_load_main_skid;
    logic                  w_load_skid;

    assign w_in_xfer  = bus.in_valid && r_in_ready;
    assign w_out_xfer = w_main_valid && bus.out_ready;

    // in_ready is registered from the next state so out_ready never reaches it combinationally
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state    <= S_EMPTY;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_next;
        r_in_ready <= (w_next != S_FULL);
      end
    end

    always_comb begin
      w_next           = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      if (bus.flush) begin
        w_next = S_EMPTY;
      end else begin
        unique case (r_state)
          S_EMPTY: begin
            if (w_in_xfer) begin
              w_next         = S_ONE;
              w_load_main_in = 1'b1;
            end
          end
          S_ONE: begin
            if (w_in_xfer && w_out_xfer) begin
              w_load_main_in = 1'b1;
            end else if (w_in_xfer) begin
              w_next      = S_FULL;
              w_load_skid = 1'b1;
            end else if (w_out_xfer) begin
              w_next = S_EMPTY;
            end
          end
          S_FULL: begin
            if (w_out_xfer) begin
              w_next           = S_ONE;
              w_load_main_skid = 1'b1;
            end
          end
          default: w_next = S_EMPTY;
        endcase
      end
    end

    always_comb begin
      w_main_valid = 1'b0;
      w_occ        = 2'd0;
      unique case (r_state)
        S_ONE: begin
          w_main_valid = 1'b1;
          w_occ        = 2'd1;
        end
        S_FULL: begin
          w_main_valid = 1'b1;
          w_occ        = 2'd2;
        end
        default: begin
          w_main_valid = 1'b0;
          w_occ        = 2'd0;
        end
      endcase
    end

    // skid always holds the newer word, so it refills main when main drains
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_main_data <= '0;
        r_skid_data <= '0;
      end else begin
        if (w_load_main_in) begin
          r_main_data <= bus.in_data;
        end else if (w_load_main_skid) begin
          r_main_data <= r_skid_data;
        end
        if (w_load_skid) begin
          r_skid_data <= bus.in_data;
        end
      end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_main_valid;
    assign bus.out_data  = r_main_data;
    assign bus.occupancy = w_occ;
  end

endmodule

// File: tb/tb_pipe_slice.sv
// Directed bench for pipe_slice: one instance per MODE, sharing clock and reset.
// Inputs change on the falling edge; outputs are read 1 time unit later, before the rising edge.
module tb_pipe_slice;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  pipe_slice_if #(.DATA_WIDTH(32)) if0 ();
  pipe_slice_if #(.DATA_WIDTH(32)) if1 ();
  pipe_slice_if #(.DATA_WIDTH(32)) if2 ();

  pipe_slice #(.DATA_WIDTH(32), .MODE(0)) u_m0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_slice #(.DATA_WIDTH(32), .MODE(1)) u_m1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_slice #(.DATA_WIDTH(32), .MODE(2)) u_m2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    if0.in_valid = 1'b0; if0.in_data = '0; if0.out_ready = 1'b0; if0.flush = 1'b0;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.out_ready = 1'b0; if1.flush = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.out_ready = 1'b0; if2.flush = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m1_valid got %b want 0", if1.out_valid); end
    n_cmp++; if (if1.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_m1_data got %h want 0", if1.out_data); end
    n_cmp++; if (if1.occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_m1_occ got %0d want 0", if1.occupancy); end
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_m1_inrdy got %b want 1", if1.in_ready); end
    n_cmp++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_m2_valid got %b want 0", if2.out_valid); end
    n_cmp++; if (if2.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_m2_data got %h want 0", if2.out_data); end
    n_cmp++; if (if2.occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_m2_occ got %0d want 0", if2.occupancy); end
    n_cmp++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_m2_inrdy got %b want 1", if2.in_ready); end
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_m0_inrdy0 got %b want 0", if0.in_ready); end
    if0.out_ready = 1'b1; #1;
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_m0_inrdy1 got %b want 1", if0.in_ready); end
    n_cmp++; if (if0.occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_m0_occ got %0d want 0", if0.occupancy); end
    if0.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_m0_bypass();
    if0.in_valid = 1'b1; if0.in_data = 32'hDEAD_BEEF; if0.out_ready = 1'b1; #1;
    n_cmp++; if (if0.out_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL m0_data got %h want deadbeef", if0.out_data); end
    n_cmp++; if (if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL m0_valid got %b want 1", if0.out_valid); end
    n_cmp++; if (if0.in_ready !== 1'b1) begin n_fail++; $display("FAIL m0_inrdy got %b want 1", if0.in_ready); end
    if0.in_valid = 1'b0; if0.out_ready = 1'b0; if0.flush = 1'b1; #1;
    n_cmp++; if (if0.out_valid !== 1'b0) begin n_fail++; $display("FAIL m0_valid0 got %b want 0", if0.out_valid); end
    n_cmp++; if (if0.in_ready !== 1'b0) begin n_fail++; $display("FAIL m0_inrdy0 got %b want 0", if0.in_ready); end
    @(negedge clk);
    idle_all();
  endtask

  task automatic test_m2_stream();
    logic [31:0] vec [3];
    vec[0] = 32'hA0; vec[1] = 32'hA1; vec[2] = 32'hA2;
    if2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if2.in_valid = (i < 3);
      if2.in_data  = (i < 3) ? vec[i] : 32'h0;
      #1;
      n_cmp++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_inrdy[%0d] got %b want 1", i, if2.in_ready); end
      if (i > 0) begin
        n_cmp++; if (if2.out_valid !== 1'b1 || if2.out_data !== vec[i-1]) begin n_fail++; $display("FAIL stream_out[%0d] got %b/%h want 1/%h", i, if2.out_valid, if2.out_data, vec[i-1]); end
        n_cmp++; if (if2.occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ[%0d] got %0d want 1", i, if2.occupancy); end
      end
      @(negedge clk);
    end
    #1;
    n_cmp++; if (if2.out_valid !== 1'b0 || if2.occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got %b/%0d want 0/0", if2.out_valid, if2.occupancy); end
    idle_all();
  endtask

  task automatic test_m2_backpressure();
    if2.out_ready = 1'b0;
    if2.in_valid = 1'b1; if2.in_data = 32'h11; @(negedge clk);
    if2.in_data = 32'h22; #1;
    n_cmp++; if (if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_inrdy_one got %b want 1", if2.in_ready); end
    @(negedge clk);
    if2.in_data = 32'h33; #1;
    n_cmp++; if (if2.occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full got %0d want 2", if2.occupancy); end
    n_cmp++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_inrdy_full got %b want 0", if2.in_ready); end
    n_cmp++; if (if2.out_data !== 32'h11) begin n_fail++; $display("FAIL bp_head got %h want 11", if2.out_data); end
    @(negedge clk);
    if2.out_ready = 1'b1; #1;
    n_cmp++; if (if2.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_inrdy_noncomb got %b want 0", if2.in_ready); end
    n_cmp++; if (if2.out_data !== 32'h11) begin n_fail++; $display("FAIL bp_out0 got %h want 11", if2.out_data); end
    @(negedge clk); #1;
    n_cmp++; if (if2.out_data !== 32'h22 || if2.in_ready !== 1'b1 || if2.occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_out1 got %h/%b/%0d want 22/1/1", if2.out_data, if2.in_ready, if2.occupancy); end
    @(negedge clk);
    if2.in_valid = 1'b0; #1;
    n_cmp++; if (if2.out_data !== 32'h33 || if2.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out2 got %h/%b want 33/1", if2.out_data, if2.out_valid); end
    @(negedge clk); #1;
    n_cmp++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_dup got valid %b want 0", if2.out_valid); end
    idle_all();
  endtask

  task automatic test_m2_toggle();
    logic [31:0] words [100];
    int          sent;
    int          recv;
    int          cyc;
    logic        want;
    logic        ir_a;
    logic        ir_b;
    logic        ov;
    logic [31:0] od;
    sent = 0; recv = 0; cyc = 0;
    for (int i = 0; i < 100; i++) words[i] = (i * 32'h0101_0101) ^ 32'h5A5A_C3C3;
    while (recv < 100 && cyc < 1000) begin
      want = (cyc % 2) == 1;
      if2.in_valid = (sent < 100);
      if2.in_data  = (sent < 100) ? words[sent] : 32'h0;
      if2.out_ready = !want; #1;
      ir_a = if2.in_ready;
      if2.out_ready = want; #1;
      ir_b = if2.in_ready;
      ov = if2.out_valid; od = if2.out_data;
      n_cmp++; if (ir_a !== ir_b) begin n_fail++; $display("FAIL tog_inrdy_comb cyc %0d got %b after out_ready flip want %b", cyc, ir_b, ir_a); end
      if (if2.in_valid && ir_b) sent++;
      if (ov && want) begin
        n_cmp++; if (od !== words[recv]) begin n_fail++; $display("FAIL tog_order[%0d] got %h want %h", recv, od, words[recv]); end
        recv++;
      end
      @(negedge clk);
      cyc++;
    end
    n_cmp++; if (recv !== 100) begin n_fail++; $display("FAIL tog_budget got %0d words want 100", recv); end
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_m1_simul();
    if1.in_valid = 1'b1; if1.in_data = 32'h55; @(negedge clk);
    if1.in_data = 32'h66; #1;
    n_cmp++; if (if1.in_ready !== 1'b0) begin n_fail++; $display("FAIL m1_inrdy_held got %b want 0", if1.in_ready); end
    if1.out_ready = 1'b1; #1;
    n_cmp++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL m1_inrdy_comb got %b want 1", if1.in_ready); end
    n_cmp++; if (if1.out_data !== 32'h55 || if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL m1_out55 got %h/%b want 55/1", if1.out_data, if1.out_valid); end
    @(negedge clk);
    if1.in_valid = 1'b0; #1;
    n_cmp++; if (if1.out_data !== 32'h66 || if1.occupancy !== 2'd1) begin n_fail++; $display("FAIL m1_out66 got %h/%0d want 66/1", if1.out_data, if1.occupancy); end
    @(negedge clk); #1;
    n_cmp++; if (if1.occupancy !== 2'd0) begin n_fail++; $display("FAIL m1_drain got %0d want 0", if1.occupancy); end
    idle_all();
  endtask

  task automatic test_flush();
    if2.in_valid = 1'b1; if2.in_data = 32'h77; @(negedge clk);
    if2.in_data = 32'h88; @(negedge clk);
    if2.in_data = 32'h99; if2.flush = 1'b1; #1;
    n_cmp++; if (if2.occupancy !== 2'd2) begin n_fail++; $display("FAIL fl_full got %0d want 2", if2.occupancy); end
    @(negedge clk);
    if2.flush = 1'b0; if2.in_valid = 1'b0; if2.out_ready = 1'b1; #1;
    n_cmp++; if (if2.out_valid !== 1'b0 || if2.occupancy !== 2'd0 || if2.in_ready !== 1'b1) begin n_fail++; $display("FAIL fl_m2_full got %b/%0d/%b want 0/0/1", if2.out_valid, if2.occupancy, if2.in_ready); end
    @(negedge clk); #1;
    n_cmp++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no99 got valid %b data %h want 0", if2.out_valid, if2.out_data); end
    // flush in ONE with an accepted input and a delivered output
    if2.in_valid = 1'b1; if2.in_data = 32'h77; if2.out_ready = 1'b0; @(negedge clk);
    if2.in_data = 32'h99; if2.out_ready = 1'b1; if2.flush = 1'b1; #1;
    n_cmp++; if (if2.out_data !== 32'h77 || if2.out_valid !== 1'b1) begin n_fail++; $display("FAIL fl_deliver got %h/%b want 77/1", if2.out_data, if2.out_valid); end
    @(negedge clk);
    if2.flush = 1'b0; if2.in_valid = 1'b0; #1;
    n_cmp++; if (if2.out_valid !== 1'b0 || if2.occupancy !== 2'd0) begin n_fail++; $display("FAIL fl_m2_one got %b/%0d want 0/0", if2.out_valid, if2.occupancy); end
    if1.in_valid = 1'b1; if1.in_data = 32'hAB; @(negedge clk);
    if1.in_data = 32'hCD; if1.out_ready = 1'b1; if1.flush = 1'b1; @(negedge clk);
    if1.flush = 1'b0; if1.in_valid = 1'b0; #1;
    n_cmp++; if (if1.out_valid !== 1'b0 || if1.occupancy !== 2'd0) begin n_fail++; $display("FAIL fl_m1 got %b/%0d want 0/0", if1.out_valid, if1.occupancy); end
    idle_all();
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    if1.in_valid = 1'b1; if1.in_data = 32'h42;
    if2.in_valid = 1'b1; if2.in_data = 32'h42;
    @(negedge clk);
    idle_all();
    #2 rst = 1'b1; #1;
    n_cmp++; if (if1.out_valid !== 1'b0 || if1.out_data !== 32'h0 || if1.occupancy !== 2'd0) begin n_fail++; $display("FAIL ar_m1 got %b/%h/%0d want 0/0/0", if1.out_valid, if1.out_data, if1.occupancy); end
    n_cmp++; if (if2.out_valid !== 1'b0 || if2.out_data !== 32'h0 || if2.occupancy !== 2'd0) begin n_fail++; $display("FAIL ar_m2 got %b/%h/%0d want 0/0/0", if2.out_valid, if2.out_data, if2.occupancy); end
    @(negedge clk);
    rst = 1'b0;
    if0.in_valid = 1'b1; if0.in_data = 32'h01; if0.out_ready = 1'b1;
    if1.in_valid = 1'b1; if1.in_data = 32'h01; if1.out_ready = 1'b1;
    if2.in_valid = 1'b1; if2.in_data = 32'h01; if2.out_ready = 1'b1;
    #1;
    n_cmp++; if (if0.out_data !== 32'h01 || if0.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_m0_lat got %h/%b want 01/1", if0.out_data, if0.out_valid); end
    n_cmp++; if (if2.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_m2_early got %b want 0", if2.out_valid); end
    @(negedge clk);
    idle_all(); if1.out_ready = 1'b1; if2.out_ready = 1'b1; #1;
    n_cmp++; if (if1.out_data !== 32'h01 || if1.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_m1_lat got %h/%b want 01/1", if1.out_data, if1.out_valid); end
    n_cmp++; if (if2.out_data !== 32'h01 || if2.out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_m2_lat got %h/%b want 01/1", if2.out_data, if2.out_valid); end
    @(negedge clk);
    idle_all();
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    idle_all();
    @(negedge clk);
    test_reset();
    test_m0_bypass();
    test_m2_stream();
    test_m2_backpressure();
    test_m2_toggle();
    test_m1_simul();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
